// File: rtl/ui_input_conditioner_pkg.sv
// Shared codes and state types for the KEY/SW input conditioner.
// Read-select codes, top sequencing states and per-bit debounce states.
package ui_input_conditioner_pkg;

   localparam logic [1:0] RDSEL_KEY    = 2'b00;
   localparam logic [1:0] RDSEL_SW     = 2'b01;
   localparam logic [1:0] RDSEL_KEYEVT = 2'b10;
   localparam logic [1:0] RDSEL_SWEVT  = 2'b11;

   typedef enum logic [1:0] {
      PRIME,
      LOAD,
      RUN
   } topState_t;

   typedef enum logic {
      STABLE,
      PENDING
   } bitState_t;

endpackage

// File: rtl/ui_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser, polarity fix and debounce FSM.
// rise/fall pulse in the cycle whose edge updates the stable value.
module ui_debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 100000,
   parameter logic RESET_VAL       = 1'b0,
   parameter logic ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic load,
   input  logic run,
   output logic stable,
   output logic rise,
   output logic fall
);
   import ui_input_conditioner_pkg::*;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          syncVal;
   logic          accept;
   logic          stableNext;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cntNext;
   bitState_t     state;
   bitState_t     stateNext;

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RESET_VAL;
         sync2 <= RESET_VAL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign syncVal = sync2 ^ ACTIVE_LOW;

   // Debounce state, counter and accepted value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= STABLE;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         stable <= stableNext;
      end
   end

   // Count consecutive mismatching cycles; accept at the last one.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      stableNext = stable;
      accept     = 1'b0;
      if (load) begin
         stateNext  = STABLE;
         cntNext    = '0;
         stableNext = syncVal;
      end else if (run) begin
         unique case (state)
            STABLE: begin
               if (syncVal != stable) begin
                  if (LAST == '0) begin
                     accept = 1'b1;
                  end else begin
                     stateNext = PENDING;
                     cntNext   = CW'(1);
                  end
               end
            end
            PENDING: begin
               if (syncVal == stable) begin
                  stateNext = STABLE;
                  cntNext   = '0;
               end else if (cnt == LAST) begin
                  accept    = 1'b1;
                  stateNext = STABLE;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + CW'(1);
               end
            end
            default: stateNext = STABLE;
         endcase
         if (accept) stableNext = syncVal;
      end
   end

   assign rise = accept & syncVal;
   assign fall = accept & ~syncVal;

endmodule

// File: rtl/ui_input_conditioner.sv
// Board KEY/SW conditioner: debounced state, sticky events and
// a combinational read port with clear-on-read event words.
module ui_input_conditioner #(
   parameter int DBITS           = 32,
   parameter int KEY_BITS        = 4,
   parameter int SW_BITS         = 10,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [KEY_BITS-1:0] KEY,
   input  logic [SW_BITS-1:0]  SW,
   input  logic                rdEn,
   input  logic [1:0]          rdSel,
   output logic [DBITS-1:0]    rdData,
   output logic                evtPend
);
   import ui_input_conditioner_pkg::*;

   topState_t           state;
   topState_t           stateNext;
   logic                primeCnt;
   logic                primeCntNext;
   logic                load;
   logic                run;
   logic [KEY_BITS-1:0] keyStable;
   logic [KEY_BITS-1:0] keyRise;
   logic [KEY_BITS-1:0] unusedKeyFall;
   logic [SW_BITS-1:0]  swStable;
   logic [SW_BITS-1:0]  swRise;
   logic [SW_BITS-1:0]  swFall;
   logic [KEY_BITS-1:0] keyEvt;
   logic [KEY_BITS-1:0] keyEvtNext;
   logic [SW_BITS-1:0]  swEvt;
   logic [SW_BITS-1:0]  swEvtNext;
   logic                clrKey;
   logic                clrSw;

   // Startup sequencer register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= PRIME;
         primeCnt <= 1'b0;
      end else begin
         state    <= stateNext;
         primeCnt <= primeCntNext;
      end
   end

   // Let synchronisers fill, load them once, then debounce forever.
   always_comb begin
      stateNext    = state;
      primeCntNext = primeCnt;
      load         = 1'b0;
      run          = 1'b0;
      unique case (state)
         PRIME: begin
            primeCntNext = 1'b1;
            if (primeCnt) stateNext = LOAD;
         end
         LOAD: begin
            load      = 1'b1;
            stateNext = RUN;
         end
         RUN: run = 1'b1;
         default: stateNext = PRIME;
      endcase
   end

   for (genvar i = 0; i < KEY_BITS; i++) begin : gKey
      ui_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_VAL      (1'b1),
         .ACTIVE_LOW     (1'b1)
      ) uBit (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (KEY[i]),
         .load   (load),
         .run    (run),
         .stable (keyStable[i]),
         .rise   (keyRise[i]),
         .fall   (unusedKeyFall[i])
      );
   end

   for (genvar i = 0; i < SW_BITS; i++) begin : gSw
      ui_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_VAL      (1'b0),
         .ACTIVE_LOW     (1'b0)
      ) uBit (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (SW[i]),
         .load   (load),
         .run    (run),
         .stable (swStable[i]),
         .rise   (swRise[i]),
         .fall   (swFall[i])
      );
   end

   assign clrKey = rdEn && (rdSel == RDSEL_KEYEVT);
   assign clrSw  = rdEn && (rdSel == RDSEL_SWEVT);

   // New events are OR-ed in after the clear, so a set always wins.
   assign keyEvtNext = (clrKey ? '0 : keyEvt) | keyRise;
   assign swEvtNext  = (clrSw ? '0 : swEvt) | swRise | swFall;

   // Sticky event words and pending flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         keyEvt  <= '0;
         swEvt   <= '0;
         evtPend <= 1'b0;
      end else begin
         keyEvt  <= keyEvtNext;
         swEvt   <= swEvtNext;
         evtPend <= (|keyEvtNext) || (|swEvtNext);
      end
   end

   // Read mux shows pre-clear values so a load never loses an event.
   always_comb begin
      rdData = '0;
      unique case (rdSel)
         RDSEL_KEY:    rdData = DBITS'(keyStable);
         RDSEL_SW:     rdData = DBITS'(swStable);
         RDSEL_KEYEVT: rdData = DBITS'(keyEvt);
         RDSEL_SWEVT:  rdData = DBITS'(swEvt);
         default:      rdData = '0;
      endcase
   end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Bench for ui_input_conditioner with a behavioural reference model,
// directed scenarios and randomized pin/read traffic.
module tb_ui_input_conditioner;

   localparam int D = 4;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  KEY     = 4'hF;
   logic [9:0]  SW      = 10'h201;
   logic        rdEn    = 1'b0;
   logic [1:0]  rdSel   = 2'b00;
   logic [31:0] rdData;
   logic        evtPend;

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   ui_input_conditioner #(
      .DBITS          (32),
      .KEY_BITS       (4),
      .SW_BITS        (10),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .KEY    (KEY),
      .SW     (SW),
      .rdEn   (rdEn),
      .rdSel  (rdSel),
      .rdData (rdData),
      .evtPend(evtPend)
   );

   // Reference model: pin sample history, run lengths of
   // disagreement, accepted values and sticky events.
   logic [3:0] mK1, mK2, mKey, mKeyEvt;
   logic [9:0] mS1, mS2, mSw, mSwEvt;
   logic       mPend;
   int         edges;
   int         runK[4];
   int         runS[10];

   task automatic modelReset();
      mK1 = 4'hF; mK2 = 4'hF; mKey = '0; mKeyEvt = '0;
      mS1 = '0;   mS2 = '0;   mSw = '0;  mSwEvt = '0;
      mPend = 1'b0;
      edges = 0;
      foreach (runK[i]) runK[i] = 0;
      foreach (runS[i]) runS[i] = 0;
   endtask

   task automatic modelStep();
      logic [3:0] kv, nk;
      logic [9:0] sv, ns;
      if (edges < 100) edges++;
      kv = ~mK2;
      sv = mS2;
      nk = mKey;
      ns = mSw;
      if (edges == 3) begin
         nk = kv;
         ns = sv;
      end else if (edges > 3) begin
         for (int i = 0; i < 4; i++) begin
            if (kv[i] != mKey[i]) begin
               runK[i]++;
               if (runK[i] == D) begin
                  nk[i] = kv[i];
                  runK[i] = 0;
               end
            end else runK[i] = 0;
         end
         for (int i = 0; i < 10; i++) begin
            if (sv[i] != mSw[i]) begin
               runS[i]++;
               if (runS[i] == D) begin
                  ns[i] = sv[i];
                  runS[i] = 0;
               end
            end else runS[i] = 0;
         end
      end
      if (rdEn && rdSel == 2'b10) mKeyEvt = '0;
      if (rdEn && rdSel == 2'b11) mSwEvt = '0;
      if (edges > 3) begin
         mKeyEvt = mKeyEvt | (nk & ~mKey);
         mSwEvt  = mSwEvt | (ns ^ mSw);
      end
      mKey  = nk;
      mSw   = ns;
      mPend = (|mKeyEvt) || (|mSwEvt);
      mK2 = mK1; mK1 = KEY;
      mS2 = mS1; mS1 = SW;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) modelReset();
      else modelStep();
   end

   function automatic logic [31:0] expRd(logic [1:0] sel);
      case (sel)
         2'b00:   return 32'(mKey);
         2'b01:   return 32'(mSw);
         2'b10:   return 32'(mKeyEvt);
         default: return 32'(mSwEvt);
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every cycle: read port and pending flag against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("rdData", rdData, expRd(rdSel));
         chk("evtPend", 32'(evtPend), 32'(mPend));
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic lit(string name, logic [1:0] sel, logic [31:0] exp);
      rdSel = sel;
      #1;
      chk(name, rdData, exp);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #1 started = 1'b1;
      #1;
      lit("rst_key", 2'b00, 32'h0);
      lit("rst_sw", 2'b01, 32'h0);
      chk("rst_pend", 32'(evtPend), 32'h0);
      step(3);
      reset_n = 1'b1;

      // Power-up switches load silently
      step(3);
      lit("t1_sw", 2'b01, 32'h201);
      lit("t1_swEvt", 2'b11, 32'h0);
      chk("t1_pend", 32'(evtPend), 32'h0);

      // KEY[2] press
      KEY = 4'hB;
      step(5);
      lit("t2_early", 2'b00, 32'h0);
      step(1);
      lit("t2_key", 2'b00, 32'h4);
      lit("t2_keyEvt", 2'b10, 32'h4);
      chk("t2_pend", 32'(evtPend), 32'h1);

      // KEY[0] bounce never accepted
      KEY = 4'hA; step(3);
      KEY = 4'hB; step(1);
      KEY = 4'hA; step(3);
      KEY = 4'hB; step(8);
      lit("t3_key", 2'b00, 32'h4);
      lit("t3_keyEvt", 2'b10, 32'h4);

      // Clear-on-read coinciding with KEY[1] acceptance
      KEY = 4'h9;
      step(5);
      rdEn = 1'b1;
      lit("t4_pre", 2'b10, 32'h4);
      step(1);
      rdEn = 1'b0;
      lit("t4_keyEvt", 2'b10, 32'h2);
      chk("t4_pend", 32'(evtPend), 32'h1);
      chk("t4_mdl", 32'(mKeyEvt), 32'h2);
      rdEn = 1'b1; rdSel = 2'b10;
      step(1);
      rdEn = 1'b0;
      chk("t4_clr", 32'(evtPend), 32'h0);

      // SW[3] change, read twice
      SW = 10'h209;
      step(6);
      chk("t5_pend", 32'(evtPend), 32'h1);
      rdEn = 1'b1;
      lit("t5_first", 2'b11, 32'h8);
      step(1);
      lit("t5_second", 2'b11, 32'h0);
      chk("t5_pendLow", 32'(evtPend), 32'h0);
      rdEn = 1'b0;

      // Reset mid-pending with an event held
      KEY = 4'hF; step(8);
      KEY = 4'hB; step(6);
      lit("t6_evt", 2'b10, 32'h4);
      chk("t6_mdl", 32'(mKeyEvt), 32'h4);
      KEY = 4'hF; step(3);
      reset_n = 1'b0;
      #1;
      lit("t6_rstEvt", 2'b10, 32'h0);
      chk("t6_rstPend", 32'(evtPend), 32'h0);
      lit("t6_rstSw", 2'b01, 32'h0);
      step(3);
      reset_n = 1'b1;
      step(3);
      lit("t6_sw", 2'b01, 32'h209);
      lit("t6_keyEvt", 2'b10, 32'h0);
      step(10);
      lit("t6_keyEvt2", 2'b10, 32'h0);
      lit("t6_swEvt2", 2'b11, 32'h0);
      chk("t6_pend", 32'(evtPend), 32'h0);

      // Random pin activity and reads
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            int b;
            b = int'($urandom_range(0, 13));
            if (b < 4) KEY[b] = ~KEY[b];
            else SW[b-4] = ~SW[b-4];
         end
         rdEn  = ($urandom_range(0, 3) == 0);
         rdSel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0;
            step(2);
            reset_n = 1'b1;
         end
         step(1);
      end

      rdEn = 1'b0;
      step(1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
